led_blink_scheduler: RTL and testbench
======================================

Name: led_blink_scheduler

Overview:
- Shares the board's blink LED (led0) between NUM_REQ requesters, e.g. status, error and debug sources.
- Each requester asks for a burst of N blinks at its own rate using a req/ack handshake.
- A round-robin arbiter grants the LED to one requester at a time. The block sequences the ON/OFF/GAP timing from a shared millisecond-tick prescaler.
- led1 is the "scheduler idle" indicator.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TICK_DIV, 24_000, clk cycles per timing tick (1 ms at 24 MHz).
- GAP_TICKS, 250, idle ticks inserted after a burst before ack.
- OWN_W, $clog2(NUM_REQ), width of owner.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- req, in, NUM_REQ, per-requester request level. Held high until ack, or dropped to abort.
- req_count, in, NUM_REQ*4, blinks requested; slice i belongs to requester i.
- req_period, in, NUM_REQ*8, ON and OFF half-period in ticks; slice i. A value of 0 is treated as 1.
- ack, out, NUM_REQ, one-cycle completion pulse to the owner.
- busy, out, 1, high when state is not IDLE.
- owner, out, OWN_W, index of the current or last granted requester.
- led0, out, 1, blink output.
- led1, out, 1, high while IDLE.

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE, led0=0, led1=1, ack=0, busy=0.
  - owner=0, last_owner=NUM_REQ-1.
  - prescaler=0, tick_cnt=0, remaining=0.
- All outputs are registered. led0, led1 and busy update on the same edge as the state change, so they are glitch-free.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick is high when the count equals TICK_DIV-1.
  - Prescaler and tick_cnt both clear on every state entry.
  - A phase ends on the edge where tick=1 and tick_cnt==P-1, where P = max(period,1) for ON/OFF and GAP_TICKS for GAP.
  - Each phase therefore lasts exactly P*TICK_DIV cycles.
- IDLE:
  - If any req bit is high, grant the first requester searching from last_owner+1 upward, wrapping modulo NUM_REQ.
  - On the same edge: owner<=grant, latch count and period from the granted slices, set remaining<=count.
  - Next state is ON, or DONE if the latched count==0.
  - Config inputs are sampled only at grant; later changes are ignored.
- ON: led0=1. At phase end go to OFF.
- OFF:
  - led0=0. At phase end, remaining<=remaining-1.
  - If remaining==1, go to GAP; otherwise go to ON.
- GAP: led0=0. At phase end go to DONE.
- DONE:
  - Lasts one cycle. ack[owner]=1 for exactly that cycle.
  - last_owner<=owner; next state is IDLE.
  - req[owner] is not re-evaluated in DONE. A requester still high in IDLE is re-arbitrated fairly.
- Abort:
  - If req[owner] is 0 during ON, OFF or GAP, go to IDLE on the next edge.
  - led0<=0, no ack, last_owner<=owner.
- Requests arriving for other requesters mid-burst wait; there is no preemption.
- Simultaneous requests resolve by round-robin only; there is no fixed priority.
- Width rules:
  - remaining is 4 bits; tick_cnt is 8 bits.
  - The prescaler is $clog2(TICK_DIV) bits and wraps only via the explicit compare, never by overflow.
- A reset asserted mid-burst forces the reset values immediately. Any pending request is re-arbitrated after release, starting from requester 0.

Test Plan (TICK_DIV=4, GAP_TICKS=2, NUM_REQ=4):
- Single burst: req[1]=1, count=2, period=3, granted at edge E0.
  - led0 high for edges E0..E12 and E24..E36, low otherwise.
  - GAP runs E48..E56; ack[1] high for exactly one cycle after E56.
  - busy=1 and led1=0 throughout; owner=1.
- Round-robin after reset: req[0] and req[2] raised together.
  - Requester 0 is served first, then 2 (grant on the edge after ack[0]).
  - Then with all four held high, the grant order is 3,0,1,2,3.
- Count=0 on requester 3: grant, then ack[3] on the next cycle. led0 never rises, no gap, busy high for 1 cycle.
- Period=0 on requester 0 with count=1: ON lasts 4 cycles, OFF 4, GAP 8; ack at grant+16.
- Abort: drop req[2] during its second ON phase.
  - led0 falls and state returns to IDLE within 1 cycle; ack stays 0.
  - A pending req[3] is granted next.
- Reset mid-OFF phase: assert reset asynchronously (not on an edge).
  - led0=0, led1=1, busy=0, ack=0 immediately.
  - After release with req[2] still high, requester 0 is searched first and 2 is granted.

Source files
------------

// File: rtl/led_blink_scheduler_if.sv
// Request/ack handshake and LED outputs shared by the blink scheduler and its requesters.
interface led_blink_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int OWN_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*4-1:0] req_count;
    logic [NUM_REQ*8-1:0] req_period;
    logic [NUM_REQ-1:0]   ack;
    logic                 busy;
    logic [OWN_W-1:0]     owner;
    logic                 led0;
    logic                 led1;

    modport master (
        output req, req_count, req_period,
        input  ack, busy, owner, led0, led1
    );

    modport slave (
        input  req, req_count, req_period,
        output ack, busy, owner, led0, led1
    );
endinterface

// File: rtl/led_blink_scheduler.sv
// Round-robin sharing of one blink LED between NUM_REQ requesters; each grant plays
// count ON/OFF blinks of the requested half-period, then a fixed gap, then acks.
module led_blink_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int TICK_DIV  = 24_000,
    parameter int GAP_TICKS = 250,
    parameter int OWN_W     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    led_blink_scheduler_if.slave bus
);
    localparam int               PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [7:0]       GAP_LEN   = 8'(GAP_TICKS);
    localparam logic [OWN_W-1:0] LAST_INIT = OWN_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_ON, S_OFF, S_GAP, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [OWN_W-1:0]   last_owner_q, last_owner_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [7:0]         tick_cnt_q, tick_cnt_d;
    logic [3:0]         remaining_q, remaining_d;
    logic [7:0]         period_q, period_d;
    logic               led0_q, led0_d;
    logic               led1_q, led1_d;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;

    logic [3:0]         cnt_slice [NUM_REQ];
    logic [7:0]         per_slice [NUM_REQ];
    logic [OWN_W-1:0]   rot_idx   [NUM_REQ];
    logic [NUM_REQ-1:0] req_rot;
    logic [OWN_W-1:0]   grant;
    logic               found;
    logic               tick;
    logic               phase_end;
    logic [7:0]         phase_len;

    // req_rot[k] is the requester k+1 places after the last owner, so the
    // lowest set bit of req_rot is the round-robin winner.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign cnt_slice[gi] = bus.req_count[gi*4 +: 4];
            assign per_slice[gi] = bus.req_period[gi*8 +: 8];
            assign rot_idx[gi]   = OWN_W'((int'(last_owner_q) + 1 + gi) % NUM_REQ);
            assign req_rot[gi]   = bus.req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant = rot_idx[0];
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                grant = rot_idx[k];
            end
        end
    end

    assign tick      = (presc_q == PRE_LAST);
    assign phase_len = (state_q == S_GAP) ? GAP_LEN : period_q;
    assign phase_end = tick && (tick_cnt_q == phase_len - 8'd1);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        remaining_d  = remaining_q;
        period_d     = period_q;
        presc_d      = tick ? '0 : presc_q + PRE_W'(1);
        tick_cnt_d   = tick ? tick_cnt_q + 8'd1 : tick_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d     = grant;
                    remaining_d = cnt_slice[grant];
                    period_d    = (per_slice[grant] == 8'd0) ? 8'd1 : per_slice[grant];
                    state_d     = (cnt_slice[grant] == 4'd0) ? S_DONE : S_ON;
                end
            end
            S_ON, S_OFF, S_GAP: begin
                // A dropped request wins over a coinciding phase end.
                if (!bus.req[owner_q]) begin
                    state_d      = S_IDLE;
                    last_owner_d = owner_q;
                end else if (phase_end) begin
                    if (state_q == S_ON) begin
                        state_d = S_OFF;
                    end else if (state_q == S_OFF) begin
                        remaining_d = remaining_q - 4'd1;
                        state_d     = (remaining_q == 4'd1) ? S_GAP : S_ON;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            presc_d    = '0;
            tick_cnt_d = '0;
        end

        // Outputs follow the next state so they change on the same edge as it.
        led0_d = (state_d == S_ON);
        led1_d = (state_d == S_IDLE);
        busy_d = (state_d != S_IDLE);
        ack_d  = '0;
        if (state_d == S_DONE) begin
            ack_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_INIT;
            presc_q      <= '0;
            tick_cnt_q   <= '0;
            remaining_q  <= '0;
            period_q     <= 8'd1;
            led0_q       <= 1'b0;
            led1_q       <= 1'b1;
            busy_q       <= 1'b0;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            presc_q      <= presc_d;
            tick_cnt_q   <= tick_cnt_d;
            remaining_q  <= remaining_d;
            period_q     <= period_d;
            led0_q       <= led0_d;
            led1_q       <= led1_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;
    assign bus.led0  = led0_q;
    assign bus.led1  = led1_q;
endmodule

// File: tb/tb_led_blink_scheduler.sv
// Self-checking bench for led_blink_scheduler: vector table, hand-written corner
// sequences, then randomized traffic against a timeline-based reference model.
module tb_led_blink_scheduler;
    localparam int NR  = 4;
    localparam int TD  = 4;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    led_blink_scheduler_if #(.NUM_REQ(NR)) bus ();

    led_blink_scheduler #(
        .NUM_REQ   (NR),
        .TICK_DIV  (TD),
        .GAP_TICKS (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] req;
        int         cnt;
        int         per;
        int         owner;
        int         lat;
        int         on;
    } vec_t;
    vec_t tbl [8];

    // Reference model: the burst is described only by its grant time and the
    // arithmetic timeline that follows from count, period and gap.
    bit m_busy;
    int m_owner, m_last, m_t, m_cnt, m_p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_cfg(input int i, input int cnt, input int per);
        bus.req_count[4*i +: 4]  = 4'(cnt);
        bus.req_period[8*i +: 8] = 8'(per);
    endtask

    task automatic set_all_cfg(input int cnt, input int per);
        for (int i = 0; i < NR; i++) set_cfg(i, cnt, per);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    function automatic int m_total();
        return (m_cnt == 0) ? 0 : (2 * m_p * m_cnt + GAP) * TD;
    endfunction

    function automatic logic [31:0] m_expect();
        logic [3:0] ack;
        logic       led0;
        ack  = '0;
        led0 = 1'b0;
        if (m_busy) begin
            if (m_t == m_total()) ack = 4'(1 << m_owner);
            led0 = (m_t < 2 * m_p * m_cnt * TD) && ((m_t % (2 * m_p * TD)) < m_p * TD);
        end
        return {23'b0, ack, m_busy, 2'(m_owner), led0, !m_busy};
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NR - 1;
        m_t     = 0;
        m_cnt   = 0;
        m_p     = 1;
    endtask

    task automatic model_step();
        int c;
        int per;
        if (!m_busy) begin
            for (int k = 1; k <= NR; k++) begin
                c = (m_last + k) % NR;
                if (bus.req[c]) begin
                    m_busy  = 1'b1;
                    m_owner = c;
                    m_t     = 0;
                    m_cnt   = int'(bus.req_count[4*c +: 4]);
                    per     = int'(bus.req_period[8*c +: 8]);
                    m_p     = (per == 0) ? 1 : per;
                    break;
                end
            end
        end else if (m_t == m_total()) begin
            $display("[TB] rnd burst done owner=%0d count=%0d period=%0d", m_owner, m_cnt, m_p);
            m_busy = 1'b0;
            m_last = m_owner;
        end else if (!bus.req[m_owner]) begin
            $display("[TB] rnd burst aborted owner=%0d at t=%0d", m_owner, m_t);
            m_busy = 1'b0;
            m_last = m_owner;
        end else begin
            m_t++;
        end
    endtask

    initial begin
        int lat, on, bad, n;
        bit done;
        logic [3:0] req_n;
        int exp_rr1 [2];
        int exp_rr2 [5];

        tbl[0] = '{4'b0010,  2,   3, 1,   56,   24};
        tbl[1] = '{4'b1000,  0,   5, 3,    0,    0};
        tbl[2] = '{4'b0001,  1,   0, 0,   16,    4};
        tbl[3] = '{4'b0101,  1,   1, 2,   16,    4};
        tbl[4] = '{4'b1111,  2,   1, 3,   24,    8};
        tbl[5] = '{4'b0110,  3,   2, 1,   56,   24};
        tbl[6] = '{4'b0001, 15,   0, 0,  128,   60};
        tbl[7] = '{4'b0100,  1, 255, 2, 2048, 1020};
        exp_rr1 = '{0, 2};
        exp_rr2 = '{3, 0, 1, 2, 3};

        // Reset is checked before the first clock edge to prove it is asynchronous.
        reset = 1'b0;
        bus.req = '0;
        set_all_cfg(0, 0);
        #1 reset = 1'b1;
        #1;
        check("rst_led0",  32'(bus.led0),  32'd0);
        check("rst_led1",  32'(bus.led1),  32'd1);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_ack",   32'(bus.ack),   32'd0);
        check("rst_owner", 32'(bus.owner), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            set_all_cfg(tbl[v].cnt, tbl[v].per);
            bus.req = tbl[v].req;
            wait_busy("tbl_grant");
            lat = 0; on = 0; bad = 0; done = 1'b0;
            for (int k = 0; k < 5000; k++) begin
                if (bus.ack != 0) begin
                    done = 1'b1;
                    break;
                end
                if (bus.led0) on++;
                if (bus.led1 || !bus.busy) bad++;
                lat++;
                @(negedge clk);
            end
            check("tbl_ack_seen", 32'(done), 32'd1);
            check("tbl_owner",    32'(bus.owner), 32'(tbl[v].owner));
            check("tbl_ack_vec",  32'(bus.ack),   32'(1 << tbl[v].owner));
            check("tbl_latency",  32'(lat),       32'(tbl[v].lat));
            check("tbl_on_cycles", 32'(on),       32'(tbl[v].on));
            check("tbl_busy_led1", 32'(bad),      32'd0);
            $display("[TB] vector %0d owner=%0d latency=%0d on=%0d", v, bus.owner, lat, on);
            bus.req = '0;
            repeat (3) @(negedge clk);
            check("tbl_idle", {30'b0, bus.busy, bus.led1}, 32'd1);
        end

        // Round-robin after reset: 0 and 2 together, then all four held high.
        bus.req = '0;
        do_reset();
        set_all_cfg(0, 1);
        bus.req = 4'b0101;
        n = 0;
        for (int k = 0; k < 200 && n < 2; k++) begin
            @(negedge clk);
            if (bus.ack != 0) begin
                check("rr1_owner", 32'(bus.owner), 32'(exp_rr1[n]));
                check("rr1_ack",   32'(bus.ack),   32'(1 << exp_rr1[n]));
                $display("[TB] rr1 grant owner=%0d", bus.owner);
                bus.req[bus.owner] = 1'b0;
                n++;
            end
        end
        check("rr1_count", 32'(n), 32'd2);
        bus.req = 4'b1111;
        n = 0;
        for (int k = 0; k < 200 && n < 5; k++) begin
            @(negedge clk);
            if (bus.ack != 0) begin
                check("rr2_owner", 32'(bus.owner), 32'(exp_rr2[n]));
                $display("[TB] rr2 grant owner=%0d", bus.owner);
                n++;
            end
        end
        check("rr2_count", 32'(n), 32'd5);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Abort of requester 2 in its second ON phase; pending 3 goes next.
        set_cfg(2, 3, 1);
        set_cfg(3, 0, 1);
        bus.req = 4'b1100;
        wait_busy("abort_grant");
        check("abort_owner", 32'(bus.owner), 32'd2);
        repeat (9) @(negedge clk);
        check("abort_on2", 32'(bus.led0), 32'd1);
        bus.req = 4'b1000;
        @(negedge clk);
        check("abort_led0", 32'(bus.led0), 32'd0);
        check("abort_idle", {30'b0, bus.busy, bus.led1}, 32'd1);
        check("abort_ack",  32'(bus.ack), 32'd0);
        @(negedge clk);
        check("abort_next_owner", 32'(bus.owner), 32'd3);
        check("abort_next_ack",   32'(bus.ack),   32'b1000);
        $display("[TB] abort sequence next owner=%0d", bus.owner);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of an OFF phase.
        set_cfg(2, 0, 1);
        bus.req = 4'b0100;
        wait_busy("rst_pre_grant");
        check("rst_pre_ack", 32'(bus.ack), 32'b0100);
        bus.req = '0;
        repeat (3) @(negedge clk);
        set_cfg(2, 2, 2);
        bus.req = 4'b0100;
        wait_busy("rst_burst_grant");
        repeat (10) @(negedge clk);
        check("rst_mid_off", {30'b0, bus.busy, bus.led0}, 32'd2);
        bus.req = 4'b1100;
        #2 reset = 1'b1;
        #1;
        check("rst_async_led0", 32'(bus.led0), 32'd0);
        check("rst_async_led1", 32'(bus.led1), 32'd1);
        check("rst_async_busy", 32'(bus.busy), 32'd0);
        check("rst_async_ack",  32'(bus.ack),  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_busy("rst_regrant");
        check("rst_regrant_owner", 32'(bus.owner), 32'd2);
        $display("[TB] reset sequence regrant owner=%0d", bus.owner);

        // Randomized traffic against the reference model.
        bus.req = '0;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req_n = bus.req;
            for (int i = 0; i < NR; i++) begin
                if (req_n[i]) begin
                    if (m_busy && m_owner == i && m_t == m_total()) req_n[i] = 1'b0;
                end else if ($urandom % 6 == 0) begin
                    req_n[i] = 1'b1;
                end
            end
            if (m_busy && m_t < m_total() && req_n[m_owner] && ($urandom % 60 == 0)) begin
                req_n[m_owner] = 1'b0;
            end
            bus.req = req_n;
            for (int i = 0; i < NR; i++) set_cfg(i, int'($urandom % 4), int'($urandom % 3));
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("rnd_outputs",
                  {23'b0, bus.ack, bus.busy, bus.owner, bus.led0, bus.led1},
                  m_expect());
        end

        bus.req = '0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
